therm_stim_gen: RTL and testbench
=================================

Name: therm_stim_gen

Overview:
- Binary-to-thermometer generator; the inverse of the flash ADC's thermometer-to-binary priority encoder.
- Drives an N-bit comparator-style thermometer word into the encoder path for self-test and loopback.
- Two sources of codes: single codes over a valid/ready handshake, or an autonomous ramp sweep from 0 to full-scale.
- The output is registered and uses the same valid/ready handshake.

Parameters:
- N, 255, thermometer width (number of comparators); CODE_W must satisfy 2^CODE_W >= N.
- CODE_W, 8, binary code width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  block accepts in_code this cycle.
- in_code  in  CODE_W  requested binary code.
- ramp_start  in  1  single-cycle request to start a ramp sweep.
- ramp_step  in  CODE_W  code increment per ramp sample; sampled on ramp_start.
- out_valid  out  1  therm_out holds a valid word.
- out_ready  in  1  downstream accepts therm_out.
- therm_out  out  N  registered thermometer word.
- busy  out  1  high while the ramp is running.
- ramp_done  out  1  one-cycle pulse after the final ramp word is accepted.

Behaviour:
- Reset: synchronous when rst_n=0 at a clk edge. It applies mid-ramp or mid-handshake and drops any pending word.
- Reset values: therm_out=0, out_valid=0, busy=0, ramp_done=0, FSM=IDLE, ramp counter=0.
- Mapping (round-trips through the encoder):
  - code 0 -> all zeros.
  - code k, 1<=k<=N-1 -> bits [k:0]=1, bits above k=0.
  - code >= N -> clamped to N-1, i.e. all ones.
- Output register loads when (!out_valid || out_ready).
- Latency: 1 cycle from the accepting handshake to out_valid.
- Handshake rules:
  - Holding: when out_valid=1 and out_ready=0, therm_out and out_valid are held stable.
  - Stall-free: with out_ready held high, throughput is one word per cycle.
  - in_ready = (state==IDLE) && !ramp_start && (!out_valid || out_ready). It is combinational, and in_ready does not depend on in_valid.
  - Acceptance: a word is accepted when in_valid && in_ready.
  - out_valid falls when the register is consumed and nothing new is loaded.
- FSM IDLE:
  - Serves in_code.
  - On ramp_start: latch step = (ramp_step==0 ? 1 : ramp_step), counter=0, go to RAMP.
  - ramp_start wins over a simultaneous in_valid; that in_code is not accepted.
- FSM RAMP:
  - busy=1, in_ready=0.
  - Each time the register loads, emit the counter value. If counter==N-1, go to DONE; else counter = min(counter+step, N-1).
  - The counter is computed at CODE_W+1 bits so there is no wrap.
  - The last word is always full-scale N-1.
  - ramp_start is ignored while in RAMP.
- FSM DONE:
  - Waits until the final word is consumed (!out_valid, or out_valid && out_ready).
  - Then pulses ramp_done for one cycle and returns to IDLE. busy stays 1 until that return.
- Backpressure during a ramp stalls the counter. No samples are skipped or duplicated.

Decomposition:
- Shared package flashadc_pkg holds:
  - N_COMP=255 and CODE_W=8.
  - Enum gen_state_t {IDLE, RAMP, DONE}.
- Sub-module bin_to_therm: combinational code -> N-bit word, including the clamp. It is shared with the checker model.
- FSM, counter and output register live in the top block.

Test Plan:
1. Reset then single codes, out_ready=1: in_code 0, 1, 100, 254 -> therm_out values 0, 0x3, bits[100:0] set, all ones. Each appears 1 cycle after acceptance; the encoder loopback returns 0, 1, 100, 254.
2. Clamp: in_code=255 with N=255 -> therm_out all ones; the encoder returns 254.
3. Backpressure: send code 50, hold out_ready=0 for 5 cycles -> therm_out/out_valid stable and in_ready=0. Release -> word consumed, next code accepted the same cycle.
4. Ramp, ramp_step=64, out_ready=1 -> codes 0, 64, 128, 192, 254. busy is high throughout; ramp_done pulses once; in_ready=0 until IDLE.
5. Ramp with ramp_step=0, plus random out_ready stalls -> 255 words 0..254 in order, none skipped or duplicated; in_valid is ignored while busy.
6. rst_n low mid-ramp at code 128 -> next cycle out_valid=0, busy=0, ramp_done=0. A new ramp_start restarts the sweep from 0.

Source files
------------

// File: rtl/flashadc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flashadc_pkg
//  Description : Shared types and sizes for the flash ADC self-test path.
//  Revision    : 1.0 - initial release
// ============================================================================
package flashadc_pkg;

   localparam int N_COMP = 255;
   localparam int CODE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } gen_state_t;

endpackage
`default_nettype wire

// File: rtl/bin_to_therm.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_therm
//  Description : Combinational binary code to comparator-style thermometer
//                word. Code 0 is all zeros, code k sets bits [k:0], codes at
//                or above N clamp to N-1 (all ones).
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_therm
   import flashadc_pkg::*;
#(
   parameter int N    = N_COMP,
   parameter int IN_W = CODE_W + 1
) (
   input  logic [IN_W-1:0] code,
   output logic [N-1:0]    therm
);

   localparam logic [IN_W-1:0] c_full_scale = IN_W'(N - 1);

   logic [IN_W-1:0] w_clamped;
   logic            w_nonzero;

   // Clamp out-of-range codes to full scale; zero is the only all-off code
   always_comb begin
      w_clamped = (code > c_full_scale) ? c_full_scale : code;
      w_nonzero = (code != '0);
   end

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         assign therm[i] = w_nonzero && (w_clamped >= IN_W'(i));
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/therm_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : therm_stim_gen
//  Description : Thermometer stimulus generator for encoder self-test.
//                Serves single codes over valid/ready or sweeps an
//                autonomous ramp from 0 to full scale; registered output
//                with the same valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module therm_stim_gen #(
   parameter int N      = flashadc_pkg::N_COMP,
   parameter int CODE_W = flashadc_pkg::CODE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              ramp_start,
   input  logic [CODE_W-1:0] ramp_step,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      therm_out,
   output logic              busy,
   output logic              ramp_done
);

   import flashadc_pkg::gen_state_t;
   import flashadc_pkg::IDLE;
   import flashadc_pkg::RAMP;
   import flashadc_pkg::DONE;

   // Counter carries one extra bit so counter+step never wraps
   localparam logic [CODE_W:0] c_full_scale = (CODE_W + 1)'(N - 1);

   gen_state_t        r_state;
   logic [CODE_W:0]   r_cnt;
   logic [CODE_W-1:0] r_step;
   logic [N-1:0]      r_therm;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;

   logic              w_load;
   logic              w_accept;
   logic              w_emit;
   logic [CODE_W:0]   w_src;
   logic [CODE_W:0]   w_sum;
   logic [CODE_W:0]   w_next_cnt;
   logic [N-1:0]      w_therm;

   // Handshake qualifiers, code source select and saturating ramp increment
   always_comb begin
      w_load     = !r_out_valid || out_ready;
      in_ready   = (r_state == IDLE) && !ramp_start && w_load;
      w_accept   = in_valid && in_ready;
      w_emit     = w_accept || (r_state == RAMP);
      w_src      = (r_state == RAMP) ? r_cnt : {1'b0, in_code};
      w_sum      = r_cnt + {1'b0, r_step};
      w_next_cnt = (w_sum > c_full_scale) ? c_full_scale : w_sum;
   end

   bin_to_therm #(
      .N    (N),
      .IN_W (CODE_W + 1)
   ) u_bin_to_therm (
      .code  (w_src),
      .therm (w_therm)
   );

   // Sequencer, ramp counter and output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_step      <= '0;
         r_therm     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (w_load) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
               r_therm <= w_therm;
            end
         end

         case (r_state)
            IDLE: begin
               if (ramp_start) begin
                  r_step  <= (ramp_step == '0) ? CODE_W'(1) : ramp_step;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RAMP;
               end
            end
            RAMP: begin
               if (w_load) begin
                  if (r_cnt == c_full_scale) begin
                     r_state <= DONE;
                  end else begin
                     r_cnt <= w_next_cnt;
                  end
               end
            end
            DONE: begin
               // Final word has been taken once the register can load again
               if (w_load) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign therm_out = r_therm;
   assign busy      = r_busy;
   assign ramp_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_therm_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_therm_stim_gen
//  Description : Self-checking bench for therm_stim_gen with a transaction
//                level reference model (queue of expected codes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_therm_stim_gen;

   localparam int N  = 255;
   localparam int CW = 8;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          in_valid   = 1'b0;
   logic [CW-1:0] in_code    = '0;
   logic          ramp_start = 1'b0;
   logic [CW-1:0] ramp_step  = '0;
   logic          out_ready  = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  therm_out;
   logic          busy;
   logic          ramp_done;

   int total = 0;
   int bad   = 0;

   therm_stim_gen #(.N(N), .CODE_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .ramp_start (ramp_start),
      .ramp_step  (ramp_step),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .therm_out  (therm_out),
      .busy       (busy),
      .ramp_done  (ramp_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected word: c+1 low ones for c>=1 (clamped to N-1), zero for c=0
   function automatic logic [N-1:0] exp_word(input int c);
      logic [N-1:0] w;
      int k;
      k = (c > N - 1) ? N - 1 : c;
      w = '1;
      if (c <= 0) return '0;
      return w >> (N - 1 - k);
   endfunction

   // Encoder loopback: index of the top set comparator
   function automatic int enc(input logic [N-1:0] w);
      if (w == '0) return 0;
      return $countones(w) - 1;
   endfunction

   int ramp_tmp[$];
   function automatic void build_ramp(input int s);
      int c;
      int st;
      st = (s == 0) ? 1 : s;
      c  = 0;
      ramp_tmp.delete();
      ramp_tmp.push_back(c);
      while (c != N - 1) begin
         c = (c + st > N - 1) ? N - 1 : c + st;
         ramp_tmp.push_back(c);
      end
   endfunction

   // Reference model state: 0 idle, 1 ramp words pending, 2 last word pending
   int  m_mode  = 0;
   bit  m_valid = 0;
   int  m_code  = 0;
   bit  m_busy  = 0;
   bit  m_done  = 0;
   int  m_q[$];
   bit  chk_en  = 0;

   function automatic bit m_in_ready();
      return (m_mode == 0) && !ramp_start && (!m_valid || out_ready);
   endfunction

   // Reference model update at each rising edge
   always @(posedge clk) begin : p_model
      bit ld;
      bit acc;
      if (!rst_n) begin
         m_mode = 0; m_valid = 0; m_code = 0; m_busy = 0; m_done = 0;
         m_q.delete();
      end else begin
         ld  = !m_valid || out_ready;
         acc = in_valid && m_in_ready();
         m_done = 0;
         case (m_mode)
            0: begin
               if (ramp_start) begin
                  build_ramp(int'(ramp_step));
                  m_q    = ramp_tmp;
                  m_mode = 1;
                  m_busy = 1;
                  if (ld) m_valid = 0;
               end else if (ld) begin
                  m_valid = acc;
                  if (acc) m_code = int'(in_code);
               end
            end
            1: begin
               if (ld) begin
                  m_code  = m_q.pop_front();
                  m_valid = 1;
                  if (m_q.size() == 0) m_mode = 2;
               end
            end
            default: begin
               if (ld) begin
                  m_valid = 0; m_done = 1; m_busy = 0; m_mode = 0;
               end
            end
         endcase
      end
   end

   bit rec_en   = 0;
   int rec_q[$];
   int done_cnt = 0;

   // Per-cycle comparison against the model, plus handshake recording
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", N'(out_valid), N'(m_valid));
         if (m_valid) chk("therm_out", therm_out, exp_word(m_code));
         chk("busy", N'(busy), N'(m_busy));
         chk("ramp_done", N'(ramp_done), N'(m_done));
         chk("in_ready", N'(in_ready), N'(m_in_ready()));
         if (ramp_done) done_cnt++;
         if (rec_en && out_valid && out_ready) rec_q.push_back(enc(therm_out));
      end
   end

   task automatic send(input int code, output int tries);
      bit acc;
      acc      = 0;
      tries    = 0;
      in_valid = 1'b1;
      in_code  = CW'(code);
      while (!acc && tries < 50) begin
         #1 acc = in_ready;
         tries++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk_i("send_accepted", int'(acc), 1);
   endtask

   task automatic pulse_ramp(input int step);
      ramp_step  = CW'(step);
      ramp_start = 1'b1;
      @(posedge clk); #1;
      ramp_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (ramp_done) seen = 1;
         else if (rnd) begin
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = $urandom_range(0, 1);
            in_code   = CW'($urandom);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rec_en    = 0;
      chk_i("ramp_done_seen", int'(seen), 1);
   endtask

   task automatic chk_list(input string nm, input int exp[5]);
      chk_i({nm, "_len"}, rec_q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk_i(nm, (i < rec_q.size()) ? rec_q[i] : -1, exp[i]);
   endtask

   initial begin : p_stim
      int t;
      int codes[5] = '{0, 1, 100, 254, 255};
      int encs[5]  = '{0, 1, 100, 254, 254};
      int r64[5]   = '{0, 64, 128, 192, 254};
      int errs;
      int n;

      // Pin the model with hand-computed values
      chk("pin_w0", exp_word(0), '0);
      chk("pin_w1", exp_word(1), 255'h3);
      chk("pin_w100", exp_word(100), {{154{1'b0}}, {101{1'b1}}});
      chk("pin_w255", exp_word(255), {N{1'b1}});
      chk_i("pin_enc100", enc(exp_word(100)), 100);
      build_ramp(64);
      chk_i("pin_ramp_len", ramp_tmp.size(), 5);
      chk_i("pin_ramp_last", ramp_tmp[4], 254);

      // Reset
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Single codes back to back, including the clamp
      for (int i = 0; i < 5; i++) begin
         send(codes[i], t);
         chk_i("t1_tries", t, 1);
         chk("t1_valid", N'(out_valid), N'(1));
         chk_i("t1_loopback", enc(therm_out), encs[i]);
         if (i == 1) chk("t1_code1", therm_out, 255'h3);
      end
      @(posedge clk); #1;
      chk("t1_drained", N'(out_valid), '0);

      // Backpressure holds the word and blocks new input
      out_ready = 1'b0;
      send(50, t);
      in_valid = 1'b1;
      in_code  = CW'(77);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_in_ready", N'(in_ready), '0);
         chk("t3_hold", therm_out, exp_word(50));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(77, t);
      chk_i("t3_same_cycle", t, 1);
      chk_i("t3_word", enc(therm_out), 77);
      @(posedge clk); #1;

      // Ramp step 64, repeated ramp_start mid-sweep is ignored
      rec_q.delete();
      done_cnt = 0;
      rec_en   = 1;
      pulse_ramp(64);
      in_valid = 1'b1;
      in_code  = CW'(9);
      pulse_ramp(3);
      wait_done(100, 0);
      chk_list("t4_codes", r64);
      @(posedge clk); #1;
      chk_i("t4_done_once", done_cnt, 1);

      // Step 0 means 1: full 0..254 sweep under random stalls
      rec_q.delete();
      rec_en = 1;
      pulse_ramp(0);
      wait_done(3000, 1);
      chk_i("t5_len", rec_q.size(), 255);
      errs = 0;
      for (int i = 0; i < rec_q.size(); i++)
         if (rec_q[i] != i) errs++;
      chk_i("t5_order_errs", errs, 0);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-ramp at code 128, then restart from 0
      pulse_ramp(64);
      n = 0;
      while (!(out_valid && enc(therm_out) == 128) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk_i("t6_reached128", enc(therm_out), 128);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t6_valid", N'(out_valid), '0);
      chk("t6_busy", N'(busy), '0);
      chk("t6_done", N'(ramp_done), '0);
      rec_q.delete();
      rec_en = 1;
      pulse_ramp(64);
      wait_done(100, 0);
      chk_list("t6_restart", r64);

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
